// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan capture path.
//   SEG_PATTERNS : active-low {g,f,e,d,c,b,a} cathode pattern for each hex value 0..F
//   SEG_BLANK    : all-segments-off pattern
//   state_t      : capture FSM states; onehot_low_idx() gives the strobed anode index
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Index of the (highest) low bit in an active-low anode vector.
  // Callers pad unused upper bits with 1s; result is meaningful only when
  // exactly one bit is low.
  function automatic int unsigned onehot_low_idx(input logic [15:0] an_n);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (!an_n[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder: maps an active-low cathode pattern back to its hex value.
//   in  seg[6:0]  : cathodes {g,f,e,d,c,b,a}, active-low
//   out hex[3:0]  : decoded value (0 when blank or unrecognised)
//   out is_blank  : all segments off; out is_bad : pattern not in the hex table
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       is_blank,
  output logic       is_bad
);

  always_comb begin
    hex      = 4'h0;
    is_blank = 1'b0;
    is_bad   = 1'b1;
    if (seg == SEG_BLANK) begin
      is_blank = 1'b1;
      is_bad   = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (seg == SEG_PATTERNS[i]) begin
          hex    = 4'(i);
          is_bad = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: samples multiplexed anode/cathode lines of a scanned display,
//   waits STABLE_CYC identical samples of a single-anode strobe, then records the
//   decoded digit. Ports: clk, reset (async active-low), an/seg in; digits, blank,
//   bad_pat, cap_valid, cap_idx, multi_anode, scan_lost out.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_DIGITS-1:0]         an,
  input  logic [6:0]                    seg,
  output logic [4*NUM_DIGITS-1:0]       digits,
  output logic [NUM_DIGITS-1:0]         blank,
  output logic [NUM_DIGITS-1:0]         bad_pat,
  output logic                          cap_valid,
  output logic [$clog2(NUM_DIGITS)-1:0] cap_idx,
  output logic                          multi_anode,
  output logic                          scan_lost
);

  localparam int IDXW = $clog2(NUM_DIGITS);
  localparam int CNTW = $clog2(STABLE_CYC + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  // Input stage: every decision is made on registered samples.
  logic [NUM_DIGITS-1:0] smp_an, prev_an;
  logic [6:0]            smp_seg, prev_seg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp_an   <= '1;
      smp_seg  <= SEG_BLANK;
      prev_an  <= '1;
      prev_seg <= SEG_BLANK;
    end else begin
      smp_an   <= an;
      smp_seg  <= seg;
      prev_an  <= smp_an;
      prev_seg <= smp_seg;
    end
  end

  logic            same;
  logic            onehot;
  logic            multi;
  logic [15:0]     an_pad;
  logic [IDXW-1:0] strobe_idx;

  always_comb begin
    an_pad                 = '1;
    an_pad[NUM_DIGITS-1:0] = smp_an;
    strobe_idx             = IDXW'(onehot_low_idx(an_pad));
    same                   = (smp_an == prev_an) && (smp_seg == prev_seg);
    onehot                 = ($countones(~smp_an) == 1);
    multi                  = ($countones(~smp_an) > 1);
  end

  logic [3:0] dec_hex;
  logic       dec_blank;
  logic       dec_bad;

  seg7_pattern_decoder u_dec (
    .seg      (smp_seg),
    .hex      (dec_hex),
    .is_blank (dec_blank),
    .is_bad   (dec_bad)
  );

  // Capture FSM
  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic            capture;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (onehot) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = CNTW'(1);
        end
      end
      ST_SETTLE: begin
        if (same) begin
          if (cnt == CNTW'(STABLE_CYC - 1)) begin
            capture   = 1'b1;
            state_nxt = ST_HOLD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNTW'(1);
          end
        end else if (onehot) begin
          // Restart settling on the new strobe/pattern.
          cnt_nxt = CNTW'(1);
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      ST_HOLD: begin
        // Already captured this strobe; only a change re-arms the FSM.
        if (!same) begin
          if (onehot) begin
            state_nxt = ST_SETTLE;
            cnt_nxt   = CNTW'(1);
          end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Per-digit result registers and strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits      <= '0;
      blank       <= '1;
      bad_pat     <= '0;
      cap_valid   <= 1'b0;
      cap_idx     <= '0;
      multi_anode <= 1'b0;
    end else begin
      cap_valid   <= capture;
      multi_anode <= multi;
      if (capture) begin
        digits[{strobe_idx, 2'b00} +: 4] <= dec_hex;
        blank[strobe_idx]                <= dec_blank;
        bad_pat[strobe_idx]              <= dec_bad;
        cap_idx                          <= strobe_idx;
      end
    end
  end

  // Timeout: saturating count of cycles since the last capture.
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
    end else if (capture) begin
      tcnt <= '0;
    end else if (tcnt != TW'(TIMEOUT_CYC)) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign scan_lost = (tcnt == TW'(TIMEOUT_CYC));

endmodule

// File: tb/tb_seg7_scan_capture.sv
module tb_seg7_scan_capture;

  localparam int STABLE = 4;
  localparam int TO     = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  an_i = 4'hF;
  logic [6:0]  seg_i = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  bad_pat;
  logic        cap_valid;
  logic [1:0]  cap_idx;
  logic        multi_anode;
  logic        scan_lost;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_capture #(
    .NUM_DIGITS  (4),
    .STABLE_CYC  (STABLE),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .an          (an_i),
    .seg         (seg_i),
    .digits      (digits),
    .blank       (blank),
    .bad_pat     (bad_pat),
    .cap_valid   (cap_valid),
    .cap_idx     (cap_idx),
    .multi_anode (multi_anode),
    .scan_lost   (scan_lost)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A capture happens on the edge where the sampled {an,seg} has been seen
  // exactly STABLE times in a row and names a single digit.
  function automatic void decode(input logic [6:0] s, output logic [3:0] h,
                                 output logic b, output logic bad);
    h = 4'h0; b = 1'b0; bad = 1'b0;
    case (s)
      7'b1000000: h = 4'h0;  7'b1111001: h = 4'h1;
      7'b0100100: h = 4'h2;  7'b0110000: h = 4'h3;
      7'b0011001: h = 4'h4;  7'b0010010: h = 4'h5;
      7'b0000010: h = 4'h6;  7'b1111000: h = 4'h7;
      7'b0000000: h = 4'h8;  7'b0010000: h = 4'h9;
      7'b0001000: h = 4'hA;  7'b0000011: h = 4'hB;
      7'b1000110: h = 4'hC;  7'b0100001: h = 4'hD;
      7'b0000110: h = 4'hE;  7'b0001110: h = 4'hF;
      7'b1111111: b = 1'b1;
      default:    bad = 1'b1;
    endcase
  endfunction

  logic [15:0] m_digits = 16'h0;
  logic [3:0]  m_blank  = 4'hF;
  logic [3:0]  m_bad    = 4'h0;
  logic        m_cap    = 1'b0;
  logic [1:0]  m_idx    = 2'd0;
  logic        m_multi  = 1'b0;
  int          m_tcnt   = 0;
  logic [10:0] last     = 11'h7FF;
  int          run      = 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_digits = 16'h0; m_blank = 4'hF; m_bad = 4'h0;
      m_cap = 1'b0; m_idx = 2'd0; m_multi = 1'b0;
      m_tcnt = 0; last = 11'h7FF; run = 1;
    end else begin
      int lows;
      int pos;
      logic [3:0] h;
      logic b, bd;
      lows = 0; pos = 0;
      for (int i = 0; i < 4; i++) if (!last[7+i]) begin lows++; pos = i; end
      m_cap   = (run == STABLE) && (lows == 1);
      m_multi = (lows > 1);
      if (m_cap) begin
        decode(last[6:0], h, b, bd);
        m_digits[pos*4 +: 4] = h;
        m_blank[pos] = b;
        m_bad[pos]   = bd;
        m_idx  = 2'(pos);
        m_tcnt = 0;
      end else if (m_tcnt < TO) begin
        m_tcnt++;
      end
      if ({an_i, seg_i} == last) begin
        if (run < 1000) run++;
      end else begin
        run  = 1;
        last = {an_i, seg_i};
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("digits",      digits,      m_digits);
    check("blank",       16'(blank),  16'(m_blank));
    check("bad_pat",     16'(bad_pat), 16'(m_bad));
    check("cap_valid",   16'(cap_valid), 16'(m_cap));
    if (m_cap) check("cap_idx", 16'(cap_idx), 16'(m_idx));
    check("multi_anode", 16'(multi_anode), 16'(m_multi));
    check("scan_lost",   16'(scan_lost), 16'(m_tcnt == TO));
  end

  // ---------------- directed stimulus ----------------
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n,
                      output int caps, output int mults, output int first);
    an_i = a; seg_i = s;
    caps = 0; mults = 0; first = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (cap_valid) begin
        caps++;
        if (first == 0) first = i;
      end
      if (multi_anode) mults++;
    end
  endtask

  initial begin
    int c, m, f, tc, tm;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_digits", digits, 16'h0000);
    check("rst_blank", 16'(blank), 16'h000F);
    check("rst_outs", {11'h0, bad_pat, cap_valid}, 16'h0);
    rst_n = 1'b1;

    // 1: single digit, latency pinned
    hold(4'b1110, 7'b0100100, 10, c, m, f);
    check("t1_caps", 16'(c), 16'd1);
    check("t1_latency", 16'(f), 16'd5);
    check("t1_digit0", 16'(digits[3:0]), 16'h2);
    check("t1_blank0", 16'(blank[0]), 16'h0);

    // 2: round-robin scan 3,0,F,blank
    tc = 0;
    hold(4'b1110, 7'b0110000, 8, c, m, f); tc += c;
    hold(4'b1101, 7'b1000000, 8, c, m, f); tc += c;
    hold(4'b1011, 7'b0001110, 8, c, m, f); tc += c;
    hold(4'b0111, 7'b1111111, 8, c, m, f); tc += c;
    check("t2_caps", 16'(tc), 16'd4);
    check("t2_digits", digits, 16'h0F03);
    check("t2_blank", 16'(blank), 16'b1000);

    // 3: segment glitching faster than the settle window
    tc = 0;
    for (int k = 0; k < 10; k++) begin
      hold(4'b1110, (k % 2 == 0) ? 7'b0000000 : 7'b1111001, 2, c, m, f);
      tc += c;
    end
    check("t3_caps", 16'(tc), 16'd0);
    check("t3_digits", digits, 16'h0F03);

    // 4: two anodes low
    hold(4'b1100, 7'b0000000, 3, c, m, f);
    tc = c; tm = m;
    hold(4'b1111, 7'b1111111, 5, c, m, f);
    tc += c; tm += m;
    check("t4_multi", 16'(tm), 16'd3);
    check("t4_caps", 16'(tc), 16'd0);

    // 5: unrecognised pattern on digit 1
    hold(4'b1101, 7'b1010101, 6, c, m, f);
    check("t5_caps", 16'(c), 16'd1);
    check("t5_bad", 16'(bad_pat), 16'b0010);
    check("t5_digit1", 16'(digits[7:4]), 16'h0);

    // 6: timeout then recovery
    hold(4'b1111, 7'b1111111, 70, c, m, f);
    check("t6_lost", 16'(scan_lost), 16'd1);
    hold(4'b1011, 7'b1111000, 6, c, m, f);
    check("t6_caps", 16'(c), 16'd1);
    check("t6_lost_clr", 16'(scan_lost), 16'd0);
    check("t6_digits", digits, 16'h0703);
    check("t6_blank", 16'(blank), 16'b1000);

    // 7: async reset in the middle of settling
    hold(4'b1110, 7'b0000000, 2, c, m, f);
    #2 rst_n = 1'b0;
    #1;
    check("t7_digits", digits, 16'h0000);
    check("t7_blank", 16'(blank), 16'h000F);
    check("t7_bad", 16'(bad_pat), 16'h0000);
    check("t7_pulses", {13'h0, cap_valid, multi_anode, scan_lost}, 16'h0);
    hold(4'b1111, 7'b1111111, 2, c, m, f);
    tc = c;
    rst_n = 1'b1;
    hold(4'b1111, 7'b1111111, 6, c, m, f);
    tc += c;
    check("t7_caps", 16'(tc), 16'd0);
    check("t7_digits_after", digits, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
